// File: rtl/tmdsdecode_pkg.sv
// Shared TMDS symbol tables, decoder output encodings and state types.
// Symbols are written in encoder bit order, w[9] first.
package tmdsdecode_pkg;

   localparam logic [9:0] CTL_TOKEN [4] = '{
      10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011
   };

   localparam logic [9:0] VGUARD_CH02 = 10'b1011001100;
   localparam logic [9:0] VGUARD_CH1  = 10'b0100110011;
   localparam logic [9:0] IGUARD      = 10'b0100110011;

   localparam logic [9:0] TERC4 [16] = '{
      10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
      10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
      10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
      10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011
   };

   typedef enum logic [1:0] {
      DT_GUARD  = 2'b00,
      DT_CTRL   = 2'b01,
      DT_ISLAND = 2'b10,
      DT_PIXEL  = 2'b11
   } dtype_e;

   typedef enum logic [1:0] {
      MODE_CTRL,
      MODE_PRE,
      MODE_VIDEO,
      MODE_ISLAND
   } mode_e;

   typedef enum logic {
      LOCK_SEARCH,
      LOCK_LOCKED
   } lock_e;

   // Everything the second stage needs to know about one received word.
   typedef struct packed {
      logic       valid;
      logic       hint;
      logic       is_ctrl;
      logic [1:0] ctl;
      logic       is_vguard;
      logic       is_iguard;
      logic       is_terc4;
      logic [3:0] aux;
      logic [7:0] pix;
   } match_t;

   localparam match_t MATCH_RESET = '{
      valid: 1'b0, hint: 1'b0, is_ctrl: 1'b1, ctl: 2'b00, is_vguard: 1'b0,
      is_iguard: 1'b0, is_terc4: 1'b0, aux: 4'h0, pix: 8'h00
   };

   // Returns {hit, index} for a TERC4 symbol.
   function automatic logic [4:0] terc4_lookup(input logic [9:0] w);
      logic [4:0] r;
      r = '0;
      for (int i = 0; i < 16; i++) begin
         if (w == TERC4[i]) r = {1'b1, 4'(i)};
      end
      return r;
   endfunction

endpackage

// File: rtl/tmdsdecode_pixel.sv
// Combinational TMDS video decode: 10-bit symbol (encoder bit order) to pixel byte.
module tmdsdecode_pixel (
   input  logic [9:0] i_w,
   output logic [7:0] o_data
);

   logic [7:0] d;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      d      = i_w[9] ? ~i_w[7:0] : i_w[7:0];
      o_data = '0;
      o_data[0] = d[0];
      for (int k = 1; k < 8; k++) begin
         o_data[k] = i_w[8] ? (d[k] ^ d[k-1]) : ~(d[k] ^ d[k-1]);
      end
   end

endmodule

// File: rtl/tmdsdecode.sv
// Single-channel TMDS receive decoder: classifies aligned words, recovers fields,
// tracks control/video/island periods and reports link lock. Two-cycle latency.
module tmdsdecode
   import tmdsdecode_pkg::*;
#(
   parameter logic [1:0] CHANNEL   = 2'b00,
   parameter int         LGTIMEOUT = 13
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic [9:0] i_word,
   input  logic       i_island_hint,
   output logic [1:0] o_dtype,
   output logic [1:0] o_ctl,
   output logic [3:0] o_aux,
   output logic [7:0] o_data,
   output logic       o_gtype,
   output logic       o_err,
   output logic       o_locked
);

   localparam logic [9:0] VGUARD = (CHANNEL == 2'b01) ? VGUARD_CH1 : VGUARD_CH02;

   logic [9:0] w;
   logic [7:0] pix;
   match_t     m_d, m_q;

   assign w = {<<{i_word}};

   tmdsdecode_pixel u_pixel (
      .i_w    (w),
      .o_data (pix)
   );

   always_comb begin
      m_d         = MATCH_RESET;
      m_d.valid   = 1'b1;
      m_d.hint    = i_island_hint;
      m_d.is_ctrl = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (w == CTL_TOKEN[i]) begin
            m_d.is_ctrl = 1'b1;
            m_d.ctl     = 2'(i);
         end
      end
      m_d.is_vguard = (w == VGUARD);
      m_d.is_iguard = (w == IGUARD);
      {m_d.is_terc4, m_d.aux} = terc4_lookup(w);
      m_d.pix = pix;
   end

   // NOTE: sequential state is written only with non-blocking assignments.
   always_ff @(posedge i_clk) begin
      if (i_reset) m_q <= MATCH_RESET;
      else         m_q <= m_d;
   end

   mode_e                mode_d, mode_q;
   lock_e                lock_d, lock_q;
   logic                 island_d, island_q;
   logic [2:0]           ctrl_cnt_d, ctrl_cnt_q;
   logic [1:0]           err_cnt_d, err_cnt_q;
   logic [LGTIMEOUT-1:0] tmo_cnt_d, tmo_cnt_q;
   dtype_e               dtype_d, dtype_q;
   logic [1:0]           ctl_d, ctl_q;
   logic [3:0]           aux_d, aux_q;
   logic [7:0]           data_d, data_q;
   logic                 gtype_d, gtype_q;
   logic                 err_d, err_q;

   logic gtype_now, guard_pre, pixel_word, island_word, tmo_expire;

   always_comb begin
      mode_d      = mode_q;
      lock_d      = lock_q;
      island_d    = island_q;
      ctrl_cnt_d  = ctrl_cnt_q;
      err_cnt_d   = err_cnt_q;
      tmo_cnt_d   = tmo_cnt_q;
      dtype_d     = dtype_q;
      ctl_d       = ctl_q;
      aux_d       = aux_q;
      data_d      = data_q;
      gtype_d     = gtype_q;
      err_d       = 1'b0;
      pixel_word  = 1'b0;
      island_word = 1'b0;
      tmo_expire  = 1'b0;
      gtype_now   = (CHANNEL == 2'b01) ? m_q.hint : m_q.is_iguard;
      // Once the period type is known, only its own guard extends the preamble.
      guard_pre   = island_q ? m_q.is_iguard : m_q.is_vguard;

      if (m_q.valid) begin
         if (m_q.is_ctrl) begin
            mode_d  = MODE_CTRL;
            dtype_d = DT_CTRL;
            ctl_d   = m_q.ctl;
         end else begin
            unique case (mode_q)
               MODE_CTRL: begin
                  if (m_q.is_vguard || m_q.is_iguard) begin
                     mode_d   = MODE_PRE;
                     island_d = gtype_now;
                     dtype_d  = DT_GUARD;
                     gtype_d  = gtype_now;
                  end else begin
                     mode_d     = MODE_VIDEO;
                     pixel_word = 1'b1;
                  end
               end
               MODE_PRE: begin
                  if (guard_pre) begin
                     dtype_d = DT_GUARD;
                     gtype_d = island_q;
                  end else if (island_q) begin
                     mode_d      = MODE_ISLAND;
                     island_word = 1'b1;
                  end else begin
                     mode_d     = MODE_VIDEO;
                     pixel_word = 1'b1;
                  end
               end
               MODE_VIDEO:  pixel_word  = 1'b1;
               MODE_ISLAND: island_word = 1'b1;
               default: ;
            endcase
         end

         if (pixel_word) begin
            dtype_d = DT_PIXEL;
            data_d  = m_q.pix;
         end

         // The ch0/2 video guard doubles as TERC4 8, so only the island guard counts here.
         if (island_word) begin
            dtype_d = DT_ISLAND;
            if (m_q.is_iguard) begin
               dtype_d = DT_GUARD;
               gtype_d = 1'b1;
            end else if (m_q.is_terc4) begin
               aux_d = m_q.aux;
            end else begin
               err_d = 1'b1;
            end
         end

         ctrl_cnt_d = !m_q.is_ctrl ? 3'd0 : (ctrl_cnt_q == 3'd7) ? 3'd7 : ctrl_cnt_q + 3'd1;
         err_cnt_d  = !err_d ? 2'd0 : (err_cnt_q == 2'd3) ? 2'd3 : err_cnt_q + 2'd1;
         if (m_q.is_ctrl)        tmo_cnt_d = '0;
         else if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + 1'b1;
         tmo_expire = !m_q.is_ctrl && (tmo_cnt_q == '1);

         unique case (lock_q)
            LOCK_SEARCH: if (m_q.is_ctrl && ctrl_cnt_q == 3'd7) lock_d = LOCK_LOCKED;
            LOCK_LOCKED: if ((err_d && err_cnt_q == 2'd3) || tmo_expire) lock_d = LOCK_SEARCH;
            default: ;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         mode_q     <= MODE_CTRL;
         lock_q     <= LOCK_SEARCH;
         island_q   <= 1'b0;
         ctrl_cnt_q <= '0;
         err_cnt_q  <= '0;
         tmo_cnt_q  <= '0;
         dtype_q    <= DT_CTRL;
         ctl_q      <= '0;
         aux_q      <= '0;
         data_q     <= '0;
         gtype_q    <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         lock_q     <= lock_d;
         island_q   <= island_d;
         ctrl_cnt_q <= ctrl_cnt_d;
         err_cnt_q  <= err_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         dtype_q    <= dtype_d;
         ctl_q      <= ctl_d;
         aux_q      <= aux_d;
         data_q     <= data_d;
         gtype_q    <= gtype_d;
         err_q      <= err_d;
      end
   end

   assign o_dtype  = dtype_q;
   assign o_ctl    = ctl_q;
   assign o_aux    = aux_q;
   assign o_data   = data_q;
   assign o_gtype  = gtype_q;
   assign o_err    = err_q;
   assign o_locked = (lock_q == LOCK_LOCKED);

endmodule

// File: tb/tb_tmdsdecode.sv
// Directed bench: one stream feeds a CHANNEL 0 decoder (short timeout) and a CHANNEL 1 decoder.
// Words go in at the falling edge; the outputs seen at a send belong to the word sent two sends earlier.
module tb_tmdsdecode;

   localparam logic [9:0] CTL0 = 10'b1101010100;
   localparam logic [9:0] CTL1 = 10'b0010101011;
   localparam logic [9:0] CTL2 = 10'b0101010100;
   localparam logic [9:0] CTL3 = 10'b1010101011;
   localparam logic [9:0] VG   = 10'b1011001100;
   localparam logic [9:0] IG   = 10'b0100110011;
   localparam logic [9:0] T0   = 10'b1010011100;
   localparam logic [9:0] T4   = 10'b0101110001;
   localparam logic [9:0] T8   = 10'b1011001100;
   localparam logic [9:0] BAD  = 10'b1111111111;
   localparam logic [9:0] P00  = 10'b0100000000;
   localparam logic [9:0] PFF  = 10'b1000000000;
   localparam logic [9:0] P5A  = 10'b0010011100;

   logic       clk = 1'b0;
   logic       i_reset;
   logic [9:0] i_word;
   logic       i_island_hint;

   logic [1:0] a_dtype, a_ctl, b_dtype, b_ctl;
   logic [3:0] a_aux, b_aux;
   logic [7:0] a_data, b_data;
   logic       a_gtype, a_err, a_locked, b_gtype, b_err, b_locked;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   tmdsdecode #(.CHANNEL(2'b00), .LGTIMEOUT(4)) u_dut_a (
      .i_clk (clk), .i_reset (i_reset), .i_word (i_word), .i_island_hint (i_island_hint),
      .o_dtype (a_dtype), .o_ctl (a_ctl), .o_aux (a_aux), .o_data (a_data),
      .o_gtype (a_gtype), .o_err (a_err), .o_locked (a_locked)
   );

   tmdsdecode #(.CHANNEL(2'b01)) u_dut_b (
      .i_clk (clk), .i_reset (i_reset), .i_word (i_word), .i_island_hint (i_island_hint),
      .o_dtype (b_dtype), .o_ctl (b_ctl), .o_aux (b_aux), .o_data (b_data),
      .o_gtype (b_gtype), .o_err (b_err), .o_locked (b_locked)
   );

   function automatic logic [9:0] rev(input logic [9:0] w);
      logic [9:0] r;
      for (int k = 0; k < 10; k++) r[k] = w[9-k];
      return r;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [9:0] w, input logic hint);
      @(negedge clk);
      i_word        = rev(w);
      i_island_hint = hint;
   endtask

   task automatic check_a_reset(input string tag);
      check({tag, "_dtype"},  8'(a_dtype),  8'h01);
      check({tag, "_ctl"},    8'(a_ctl),    8'h00);
      check({tag, "_aux"},    8'(a_aux),    8'h00);
      check({tag, "_data"},   a_data,       8'h00);
      check({tag, "_gtype"},  8'(a_gtype),  8'h00);
      check({tag, "_err"},    8'(a_err),    8'h00);
      check({tag, "_locked"}, 8'(a_locked), 8'h00);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset, holding the first control token on the input.
      i_reset       = 1'b1;
      i_word        = rev(CTL0);
      i_island_hint = 1'b0;
      repeat (3) @(negedge clk);
      check_a_reset("reset");
      check("reset_b_dtype", 8'(b_dtype), 8'h01);
      i_reset = 1'b0;

      // Lock: words 1..8 are CTL0; lock rises with the eighth.
      repeat (7) send(CTL0, 1'b0);
      send(CTL1, 1'b0);                                 // shows word 7
      check("lock_after7", 8'(a_locked), 8'h00);
      send(CTL2, 1'b0);                                 // shows word 8
      check("lock_after8", 8'(a_locked), 8'h01);
      check("ctl0_dtype",  8'(a_dtype),  8'h01);
      check("ctl0_value",  8'(a_ctl),    8'h00);
      send(CTL3, 1'b0);
      check("ctl1_value",  8'(a_ctl),    8'h01);
      send(CTL0, 1'b0);
      check("ctl2_value",  8'(a_ctl),    8'h02);

      // Video period: CTL0, VG, VG, 0x00, 0xFF, 0x5A.
      send(VG, 1'b0);
      check("ctl3_value",  8'(a_ctl),    8'h03);
      send(VG, 1'b0);
      send(P00, 1'b0);
      check("vguard1_dtype", 8'(a_dtype), 8'h00);
      check("vguard1_gtype", 8'(a_gtype), 8'h00);
      send(PFF, 1'b0);
      check("vguard2_dtype", 8'(a_dtype), 8'h00);
      send(P5A, 1'b0);
      check("pix00_dtype", 8'(a_dtype), 8'h03);
      check("pix00_data",  a_data,      8'h00);
      send(CTL0, 1'b0);
      check("pixff_data",  a_data,      8'hFF);
      send(IG, 1'b0);
      check("pix5a_data",  a_data,      8'h5A);
      check("pix5a_gtype", 8'(a_gtype), 8'h00);

      // Island period: CTL0, IG, IG, TERC4 8 (same bits as the video guard), TERC4 4.
      send(IG, 1'b0);
      check("island_ctl_dtype", 8'(a_dtype), 8'h01);
      send(T8, 1'b0);
      check("iguard1_dtype", 8'(a_dtype), 8'h00);
      check("iguard1_gtype", 8'(a_gtype), 8'h01);
      send(T4, 1'b0);
      check("iguard2_dtype", 8'(a_dtype), 8'h00);
      send(BAD, 1'b0);
      check("aux8_dtype", 8'(a_dtype), 8'h02);
      check("aux8_value", 8'(a_aux),   8'h08);
      check("aux8_err",   8'(a_err),   8'h00);
      send(BAD, 1'b0);
      check("aux4_value", 8'(a_aux),   8'h04);

      // Four illegal island words while locked.
      send(BAD, 1'b0);
      check("err1_pulse",  8'(a_err),    8'h01);
      check("err1_dtype",  8'(a_dtype),  8'h02);
      check("err1_aux",    8'(a_aux),    8'h04);
      check("err1_locked", 8'(a_locked), 8'h01);
      send(BAD, 1'b0);
      check("err2_pulse",  8'(a_err),    8'h01);
      send(CTL0, 1'b0);
      check("err3_pulse",  8'(a_err),    8'h01);
      check("err3_locked", 8'(a_locked), 8'h01);
      send(CTL0, 1'b0);
      check("err4_pulse",  8'(a_err),    8'h01);
      check("err4_locked", 8'(a_locked), 8'h00);
      send(CTL0, 1'b0);
      check("err_cleared", 8'(a_err),    8'h00);

      // CHANNEL 1, hint low: guards then T0/T4 decode as pixels 0x5B, 0x93.
      send(IG, 1'b0);
      send(IG, 1'b0);
      send(T0, 1'b0);
      check("ch1_h0_guard", 8'(b_dtype), 8'h00);
      check("ch1_h0_gtype", 8'(b_gtype), 8'h00);
      send(T4, 1'b0);
      send(CTL0, 1'b0);
      check("ch1_h0_dtype", 8'(b_dtype), 8'h03);
      check("ch1_h0_pix0",  b_data,      8'h5B);
      send(IG, 1'b1);
      check("ch1_h0_pix1",  b_data,      8'h93);

      // CHANNEL 1, hint high: the same words decode as TERC4 0 and 4.
      send(IG, 1'b1);
      check("ch1_ctl_dtype", 8'(b_dtype), 8'h01);
      send(T0, 1'b1);
      check("ch1_h1_gtype",  8'(b_gtype), 8'h01);
      send(T4, 1'b0);
      send(CTL0, 1'b0);
      check("ch1_h1_dtype",  8'(b_dtype), 8'h02);
      check("ch1_h1_aux0",   8'(b_aux),   8'h00);
      send(CTL0, 1'b0);
      check("ch1_h1_aux4",   8'(b_aux),   8'h04);
      check("ch1_data_held", b_data,      8'h93);

      // Relock (words CTL0 x8), then 16 pixel words with no control token.
      repeat (6) send(CTL0, 1'b0);
      send(P00, 1'b0);                                  // shows 7th token
      check("relock_after7", 8'(a_locked), 8'h00);
      send(P00, 1'b0);                                  // shows 8th token
      check("relock_after8", 8'(a_locked), 8'h01);
      repeat (14) send(P00, 1'b0);                      // last shows pixel 14
      send(P00, 1'b0);                                  // shows pixel 15
      check("tmo_pix15_locked", 8'(a_locked), 8'h01);
      send(P00, 1'b0);                                  // shows pixel 16
      check("tmo_pix16_locked", 8'(a_locked), 8'h00);
      check("tmo_pix16_dtype",  8'(a_dtype),  8'h03);

      // Reset mid-stream.
      send(PFF, 1'b0);
      send(PFF, 1'b0);
      send(PFF, 1'b0);
      check("prereset_data", a_data, 8'hFF);
      @(negedge clk);
      i_reset = 1'b1;
      @(negedge clk);
      check_a_reset("midreset");
      i_reset = 1'b0;
      @(negedge clk);
      check("discard_dtype", 8'(a_dtype), 8'h01);
      check("discard_data",  a_data,      8'h00);
      check("discard_err",   8'(a_err),   8'h00);
      @(negedge clk);
      check("postreset_dtype", 8'(a_dtype), 8'h03);
      check("postreset_data",  a_data,      8'hFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/tmdsdecode.md
# tmdsdecode

Single-channel TMDS receive-side decoder. Accepts one 10-bit word per clock, already word-aligned by the deserializer, in the same bit order the HDMI transmit encoder emits. Classifies each word as control token, guard band, TERC4 data-island symbol or video pixel, and recovers the original fields. Tracks control/video/island periods, flags island coding errors and reports link lock; one instance per channel sits between the deserializer and the HDMI frame parser.

## Interface
- `CHANNEL`, default 2'b00: channel index 0/1/2, selecting the video guard pattern; 2'b11 is illegal.
- `LGTIMEOUT`, default 13: log2 of the words allowed without a control token before lock drops.
- `i_clk`  in  1  system/pixel clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_word`  in  10  received word in transmit order; i_word[0] is encoder-internal bit 9.
- `i_island_hint`  in  1  used only when CHANNEL==1: high while channel 0 reports island mode.
- `o_dtype`  out  2  00 guard, 01 control, 10 data island, 11 pixel.
- `o_ctl`  out  2  decoded control bits; held otherwise.
- `o_aux`  out  4  decoded TERC4 nibble; held otherwise.
- `o_data`  out  8  decoded pixel byte; held otherwise.
- `o_gtype`  out  1  guard type of the last guard word: 0 video, 1 data.
- `o_err`  out  1  one-cycle pulse: island-mode word matched no legal code.
- `o_locked`  out  1  link lock status.

## Operation
- Un-reverse the input: w[k] = i_word[9-k]. All patterns below use w[9:0], MSB first.
- Control tokens:
  - 1101010100 → ctl 00
  - 0010101011 → ctl 01
  - 0101010100 → ctl 10
  - 1010101011 → ctl 11
- Guard words:
  - Video guard: 1011001100 for CHANNEL 0/2, 0100110011 for CHANNEL 1.
  - Island guard: 0100110011.
- TERC4 codes, aux 0..F:
  - 0–3: 1010011100, 1001100011, 1011100100, 1011100010
  - 4–7: 0101110001, 0100011110, 0110001110, 0100111100
  - 8–B: 1011001100, 0100111001, 0110011100, 1011000110
  - C–F: 1010001110, 1001110001, 0101100011, 1011000011
- Pixel decode:
  - d = w[9] ? ~w[7:0] : w[7:0].
  - data[0] = d[0].
  - For k = 1..7: data[k] = d[k]^d[k-1] when w[8]=1, otherwise ~(d[k]^d[k-1]).
- Mode FSM states: CTRL, PRE, VIDEO, ISLAND.
  - Any control token → CTRL, from any state.
  - CTRL + guard word → PRE, latching island = (CHANNEL==1 ? i_island_hint : w==island guard).
  - PRE + guard word → stay in PRE.
  - PRE + other word → VIDEO or ISLAND per the latched flag; that word is decoded in the new mode.
  - CTRL + a non-control, non-guard word → VIDEO (tolerates lost guards).
- Classification priority:
  - control token > guard (in CTRL/PRE, or in ISLAND) > TERC4 (ISLAND) > pixel (VIDEO, or CTRL fallback).
  - 1011001100 is both the ch0/2 video guard and TERC4 8. In ISLAND it decodes as aux 8, never as guard.
- Errors: in ISLAND, a word that is not a control token, island guard or TERC4 code gives o_err=1 and o_dtype=10. Fields are held.
- Lock FSM states: SEARCH, LOCKED.
  - SEARCH → LOCKED after 8 consecutive control tokens.
  - LOCKED → SEARCH after 4 consecutive o_err, or after 2^LGTIMEOUT consecutive words with no control token.
  - Counters saturate. A control token clears the timeout counter; a non-error word clears the error counter.

## Timing
- Stage 1 registers w, the match flags (ctrl/guard/TERC4 index) and the pixel pre-decode.
- Stage 2 registers all outputs and advances both FSMs.
- Latency: word at i_word in cycle n appears on the outputs in cycle n+2; one word per clock, no stalls.
- Reset, synchronous and taking effect the next cycle:
  - o_dtype=01, o_ctl=00, o_aux=0, o_data=0, o_gtype=0, o_err=0, o_locked=0.
  - Mode=CTRL, lock=SEARCH, all counters 0; pipeline registers cleared to a 00 control token.
- Reset mid-stream discards both in-flight words; they produce no o_err.
- Simultaneous conditions in LOCKED: a timeout expiry and a control token in the same cycle resolve as the control token (stay LOCKED).

## Structure
- Shared HDMI package holds:
  - the four control tokens, three guard patterns and the 16-entry TERC4 table, shared with the encoder;
  - the o_dtype encodings;
  - the mode/lock state enums.
- One natural sub-module, `tmdsdecode_pixel`: the combinational 10→8 pixel decoder, reusable by loopback checkers.

## Test plan
- Reset, then 8× control word 1101010100 → o_dtype=01, o_ctl=00, o_locked=1 at cycle 10 after first word.
- Control, 2× 1011001100 (CHANNEL=0), then encoder output for bytes 0x00, 0xFF, 0x5A → o_dtype=00,00 then 11 with o_data 0x00, 0xFF, 0x5A, o_gtype=0.
- Control, 2× 0100110011, then 1011001100, 0101110001 → o_gtype=1, o_dtype=10, o_aux=8 then 4.
- In ISLAND, word 1111111111 ×4 while LOCKED → four o_err pulses, o_locked=0 after the fourth.
- CHANNEL=1 with i_island_hint=0 vs 1 over identical guard+data stream → pixel vs aux decode.
- LGTIMEOUT=4: 16 pixel words with no control → o_locked falls exactly after the 16th; assert i_reset mid-stream → all outputs at reset values next cycle.
